// File: rtl/rv32im_dmem_ctrl_pkg.sv
// Shared widths, size codes and FSM states for the data-memory controller.
package rv32im_dmem_ctrl_pkg;

   localparam int API_DATA_WIDTH = 32;

   localparam logic [1:0] DMEM_SIZE_B = 2'b00;
   localparam logic [1:0] DMEM_SIZE_H = 2'b01;
   localparam logic [1:0] DMEM_SIZE_W = 2'b10;

   typedef enum logic [1:0] {
      DMEM_IDLE,
      DMEM_ACC0,
      DMEM_ACC1,
      DMEM_RESP
   } dmem_state_e;

   function automatic logic [3:0] size_mask(input logic [1:0] size);
      logic [3:0] m;
      case (size)
         DMEM_SIZE_B: m = 4'b0001;
         DMEM_SIZE_H: m = 4'b0011;
         default:     m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/rv32im_dmem_align.sv
// Byte-lane alignment of a request across a two-word window.
module rv32im_dmem_align
   import rv32im_dmem_ctrl_pkg::*;
(
   input  logic [1:0]                  off,
   input  logic [1:0]                  size,
   input  logic [API_DATA_WIDTH-1:0]   wdata,
   output logic [7:0]                  be8,
   output logic [2*API_DATA_WIDTH-1:0] wdata64,
   output logic                        split
);

   always_comb begin
      be8     = {4'b0000, size_mask(size)} << off;
      wdata64 = {{API_DATA_WIDTH{1'b0}}, wdata} << {off, 3'b000};
      split   = |be8[7:4];
   end

endmodule

// File: rtl/rv32im_dmem_ctrl.sv
// Data-memory controller: lane alignment, split word accesses, read merge.
module rv32im_dmem_ctrl
   import rv32im_dmem_ctrl_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic                      req_we_i,
   input  logic [1:0]                req_size_i,
   input  logic [API_DATA_WIDTH-1:0] req_addr_i,
   input  logic [API_DATA_WIDTH-1:0] req_wdata_i,
   output logic                      rsp_valid_o,
   output logic [API_DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                      bus_req_o,
   output logic                      bus_we_o,
   output logic [API_DATA_WIDTH-1:0] bus_addr_o,
   output logic [3:0]                bus_be_o,
   output logic [API_DATA_WIDTH-1:0] bus_wdata_o,
   input  logic                      bus_ack_i,
   input  logic [API_DATA_WIDTH-1:0] bus_rdata_i
);

   dmem_state_e state, state_nxt;

   logic [7:0]  be8;
   logic [63:0] wdata64;
   logic        split;

   logic        we_q;
   logic [1:0]  size_q;
   logic [1:0]  off_q;
   logic        split_q;
   logic [3:0]  be_hi_q;
   logic [31:0] wdata_hi_q;
   logic [31:0] lo_q;
   logic [31:0] hi_q;
   logic [31:0] shifted;
   logic        accept;

   rv32im_dmem_align u_align (
      .off     (req_addr_i[1:0]),
      .size    (req_size_i),
      .wdata   (req_wdata_i),
      .be8     (be8),
      .wdata64 (wdata64),
      .split   (split)
   );

   assign req_ready_o = (state == DMEM_IDLE) && !rst_i;
   assign accept      = req_valid_i && req_ready_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= DMEM_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         DMEM_IDLE: if (accept) state_nxt = DMEM_ACC0;
         DMEM_ACC0: if (bus_ack_i)
            state_nxt = split_q ? DMEM_ACC1 : DMEM_RESP;
         DMEM_ACC1: if (bus_ack_i) state_nxt = DMEM_RESP;
         default:   state_nxt = DMEM_IDLE;
      endcase
   end

   // Bus outputs are registered so they stay put through wait states.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_be_o    <= '0;
         bus_wdata_o <= '0;
         we_q        <= 1'b0;
         size_q      <= '0;
         off_q       <= '0;
         split_q     <= 1'b0;
         be_hi_q     <= '0;
         wdata_hi_q  <= '0;
         lo_q        <= '0;
         hi_q        <= '0;
      end else begin
         case (state)
            DMEM_IDLE: if (accept) begin
               we_q        <= req_we_i;
               size_q      <= req_size_i;
               off_q       <= req_addr_i[1:0];
               split_q     <= split;
               be_hi_q     <= be8[7:4];
               wdata_hi_q  <= wdata64[63:32];
               lo_q        <= '0;
               hi_q        <= '0;
               bus_req_o   <= 1'b1;
               bus_we_o    <= req_we_i;
               bus_addr_o  <= {req_addr_i[31:2], 2'b00};
               bus_be_o    <= be8[3:0];
               bus_wdata_o <= wdata64[31:0];
            end
            DMEM_ACC0: if (bus_ack_i) begin
               lo_q <= bus_rdata_i;
               if (split_q) begin
                  bus_addr_o  <= bus_addr_o + 32'd4;
                  bus_be_o    <= be_hi_q;
                  bus_wdata_o <= wdata_hi_q;
               end else begin
                  bus_req_o   <= 1'b0;
                  bus_we_o    <= 1'b0;
                  bus_addr_o  <= '0;
                  bus_be_o    <= '0;
                  bus_wdata_o <= '0;
               end
            end
            DMEM_ACC1: if (bus_ack_i) begin
               hi_q        <= bus_rdata_i;
               bus_req_o   <= 1'b0;
               bus_we_o    <= 1'b0;
               bus_addr_o  <= '0;
               bus_be_o    <= '0;
               bus_wdata_o <= '0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      shifted     = 32'({hi_q, lo_q} >> {off_q, 3'b000});
      rsp_valid_o = (state == DMEM_RESP);
      rsp_rdata_o = '0;
      if (rsp_valid_o && !we_q) begin
         case (size_q)
            DMEM_SIZE_B: rsp_rdata_o = {24'd0, shifted[7:0]};
            DMEM_SIZE_H: rsp_rdata_o = {16'd0, shifted[15:0]};
            default:     rsp_rdata_o = shifted;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32im_dmem_ctrl.sv
// Directed bench for rv32im_dmem_ctrl with a scripted bus responder.
module tb_rv32im_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   rv32im_dmem_ctrl dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_size_i  (req_size),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .bus_req_o   (bus_req),
      .bus_we_o    (bus_we),
      .bus_addr_o  (bus_addr),
      .bus_be_o    (bus_be),
      .bus_wdata_o (bus_wdata),
      .bus_ack_i   (bus_ack),
      .bus_rdata_i (bus_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bus(input string nm, input logic we,
                          input logic [31:0] ea, input logic [3:0] eb,
                          input logic [31:0] ew);
      check({nm, ".req"}, {31'd0, bus_req}, 32'd1);
      check({nm, ".we"}, {31'd0, bus_we}, {31'd0, we});
      check({nm, ".addr"}, bus_addr, ea);
      check({nm, ".be"}, {28'd0, bus_be}, {28'd0, eb});
      check({nm, ".wdata"}, bus_wdata, ew);
   endtask

   task automatic xact(input string nm, input logic we,
                       input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int n,
                       input logic [31:0] ea0, input logic [3:0] eb0,
                       input logic [31:0] ew0, input logic [31:0] rd0,
                       input logic [31:0] ea1, input logic [3:0] eb1,
                       input logic [31:0] ew1, input logic [31:0] rd1,
                       input int waits, input logic [31:0] erd);
      check({nm, ".rdy"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_size  = sz;
      req_addr  = a;
      req_wdata = wd;
      step();
      req_valid = 1'b0;
      for (int t = 0; t < n; t++) begin
         string sn;
         sn = $sformatf("%s.a%0d", nm, t);
         chk_bus(sn, we, t ? ea1 : ea0, t ? eb1 : eb0, t ? ew1 : ew0);
         for (int w = 0; w < waits; w++) begin
            // A competing request during wait states must be ignored.
            req_valid = 1'b1;
            req_addr  = 32'h0000_0F00;
            req_we    = ~we;
            check({sn, ".busy"}, {31'd0, req_ready}, 32'd0);
            check({sn, ".norsp"}, {31'd0, rsp_valid}, 32'd0);
            step();
            chk_bus({sn, ".hold"}, we, t ? ea1 : ea0, t ? eb1 : eb0,
                    t ? ew1 : ew0);
         end
         req_valid = 1'b0;
         check({sn, ".norsp"}, {31'd0, rsp_valid}, 32'd0);
         bus_ack   = 1'b1;
         bus_rdata = t ? rd1 : rd0;
         step();
         bus_ack   = 1'b0;
         bus_rdata = '0;
      end
      check({nm, ".rsp"}, {31'd0, rsp_valid}, 32'd1);
      check({nm, ".rdata"}, rsp_rdata, erd);
      check({nm, ".busoff"}, {31'd0, bus_req}, 32'd0);
      check({nm, ".be0"}, {28'd0, bus_be}, 32'd0);
      check({nm, ".addr0"}, bus_addr, 32'd0);
      step();
      check({nm, ".rsp1"}, {31'd0, rsp_valid}, 32'd0);
      check({nm, ".rdy1"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_size  = 2'b00;
      req_addr  = '0;
      req_wdata = '0;
      bus_ack   = 1'b0;
      bus_rdata = '0;
      step();
      step();
      check("rst.ready", {31'd0, req_ready}, 32'd0);
      check("rst.busreq", {31'd0, bus_req}, 32'd0);
      check("rst.be", {28'd0, bus_be}, 32'd0);
      check("rst.addr", bus_addr, 32'd0);
      check("rst.wdata", bus_wdata, 32'd0);
      check("rst.rsp", {31'd0, rsp_valid}, 32'd0);
      check("rst.rdata", rsp_rdata, 32'd0);
      rst = 1'b0;
      #1;
      check("rst.ready1", {31'd0, req_ready}, 32'd1);
      step();

      xact("lw", 1'b0, 2'b10, 32'h100, 32'h0, 1,
           32'h100, 4'b1111, 32'h0, 32'hDEADBEEF,
           32'h0, 4'b0000, 32'h0, 32'h0, 0, 32'hDEADBEEF);
      xact("lb", 1'b0, 2'b00, 32'h103, 32'h0, 1,
           32'h100, 4'b1000, 32'h0, 32'h12345678,
           32'h0, 4'b0000, 32'h0, 32'h0, 0, 32'h00000012);
      xact("sw_split", 1'b1, 2'b10, 32'h102, 32'hAABBCCDD, 2,
           32'h100, 4'b1100, 32'hCCDD0000, 32'hFFFFFFFF,
           32'h104, 4'b0011, 32'h0000AABB, 32'hFFFFFFFF, 0, 32'h0);
      xact("lh_split", 1'b0, 2'b01, 32'h103, 32'h0, 2,
           32'h100, 4'b1000, 32'h0, 32'h11223344,
           32'h104, 4'b0001, 32'h0, 32'h55667788, 0, 32'h00008811);
      xact("wrap", 1'b0, 2'b10, 32'hFFFFFFFE, 32'h0, 2,
           32'hFFFFFFFC, 4'b1100, 32'h0, 32'hAABBCCDD,
           32'h0, 4'b0011, 32'h0, 32'h11223344, 0, 32'h3344AABB);
      xact("sh", 1'b1, 2'b01, 32'h001, 32'h00001234, 1,
           32'h000, 4'b0110, 32'h00123400, 32'h0,
           32'h0, 4'b0000, 32'h0, 32'h0, 0, 32'h0);
      xact("lw_sz3", 1'b0, 2'b11, 32'h200, 32'h0, 1,
           32'h200, 4'b1111, 32'h0, 32'hCAFEF00D,
           32'h0, 4'b0000, 32'h0, 32'h0, 0, 32'hCAFEF00D);
      xact("sb_wait", 1'b1, 2'b00, 32'h101, 32'h000000A5, 1,
           32'h100, 4'b0010, 32'h0000A500, 32'h0,
           32'h0, 4'b0000, 32'h0, 32'h0, 3, 32'h0);
      xact("lh_wait", 1'b0, 2'b01, 32'h3FF, 32'h0, 2,
           32'h3FC, 4'b1000, 32'h0, 32'hAB000000,
           32'h400, 4'b0001, 32'h0, 32'h000000CD, 2, 32'h0000CDAB);

      // Reset while the second half of a split access is in flight.
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = 2'b10;
      req_addr  = 32'h0FE;
      step();
      req_valid = 1'b0;
      bus_ack   = 1'b1;
      bus_rdata = 32'h01020304;
      step();
      bus_ack   = 1'b0;
      check("rst_acc1.req", {31'd0, bus_req}, 32'd1);
      check("rst_acc1.addr", bus_addr, 32'h100);
      check("rst_acc1.be", {28'd0, bus_be}, 32'h3);
      rst = 1'b1;
      step();
      check("rst_acc1.busoff", {31'd0, bus_req}, 32'd0);
      check("rst_acc1.norsp", {31'd0, rsp_valid}, 32'd0);
      check("rst_acc1.busy", {31'd0, req_ready}, 32'd0);
      rst = 1'b0;
      #1;
      check("rst_acc1.rdy", {31'd0, req_ready}, 32'd1);
      step();
      check("rst_acc1.norsp1", {31'd0, rsp_valid}, 32'd0);
      check("rst_acc1.busoff1", {31'd0, bus_req}, 32'd0);

      xact("post_rst", 1'b0, 2'b00, 32'h005, 32'h0, 1,
           32'h004, 4'b0010, 32'h0, 32'h0000EE00,
           32'h0, 4'b0000, 32'h0, 32'h0, 0, 32'h000000EE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rv32im_dmem_ctrl.md
# rv32im_dmem_ctrl

Data-memory access controller sitting directly downstream of `rv32im_lsu`, between the core's load/store path and the external data bus. It accepts one load or store request at a time and aligns store data into byte lanes with byte enables. Accesses that cross a word boundary are split into two word-aligned bus transactions, and read data is merged back right-justified and zero-extended. Sign extension and final result formatting remain in the LSU.

## Interface
Parameters:
- none. Widths come from the shared defines: `API_DATA_WIDTH` = 32.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `req_valid_i`  in  1  core request valid
- `req_ready_o`  out  1  controller idle; request is accepted when valid && ready
- `req_we_i`  in  1  1 = store, 0 = load
- `req_size_i`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `req_addr_i`  in  32  byte address; any alignment allowed
- `req_wdata_i`  in  32  store data, right-justified
- `rsp_valid_o`  out  1  one-cycle completion pulse, for loads and stores
- `rsp_rdata_o`  out  32  load data, right-justified, zero-extended; 0 for stores
- `bus_req_o`  out  1  bus transaction request
- `bus_we_o`  out  1  bus write
- `bus_addr_o`  out  32  word address; bits [1:0] are always 0
- `bus_be_o`  out  4  byte enables
- `bus_wdata_o`  out  32  lane-aligned write data
- `bus_ack_i`  in  1  transaction complete; `bus_rdata_i` is valid in the same cycle
- `bus_rdata_i`  in  32  read word

## Operation
- **FSM states:** IDLE, ACC0, ACC1, RESP.
- **IDLE:**
  - `req_ready_o` = (state == IDLE) && !`rst_i`.
  - On accept, register we/size/addr/wdata, then go to ACC0.
- **Lane computation:**
  - off = addr[1:0].
  - Base mask: byte 0001, half 0011, word 1111.
  - be8 = mask << off.
  - wdata64 = {32'b0, wdata} << (8*off).
  - split = |be8[7:4].
- **ACC0:**
  - Drive bus_req=1, bus_addr = {addr[31:2], 2'b00}, bus_be = be8[3:0], bus_wdata = wdata64[31:0].
  - On ack: capture rdata into lo, then go to ACC1 if split, else RESP.
- **ACC1:**
  - Drive bus_addr = {addr[31:2], 2'b00} + 4, computed modulo 2^32 so 0xFFFFFFFC wraps to 0x00000000.
  - Drive bus_be = be8[7:4], bus_wdata = wdata64[63:32].
  - On ack: capture hi, then go to RESP.
- **RESP:**
  - `rsp_valid_o` = 1.
  - `rsp_rdata_o` = ({hi, lo} >> 8*off)[31:0], with unused upper bytes zeroed per size. Stores return 0.
  - Next state is IDLE.
- **Bus rules:**
  - All bus outputs are registered and held stable while bus_req=1 until ack.
  - bus_req drops in the cycle after ack. At most one transaction is outstanding.
  - Outside ACC0/ACC1, bus_req=0 and be/wdata/addr = 0.
- **Busy:** `req_valid_i` while busy is ignored. The core must hold the request until ready.
- **Reset:**
  - All outputs are 0 after reset, except `req_ready_o`, which is 1 once `rst_i` deasserts.
  - Reset mid-transaction abandons it: no rsp_valid, bus_req=0 in the cycle after the reset edge. The bus must tolerate a withdrawn request.

## Timing
- Aligned access with 0-wait ack: accept at T, bus_req at T+1, ack at T+1, rsp_valid at T+2, req_ready at T+3.
- Split access adds the second transaction's cycles: with 0-wait acks, rsp_valid at T+3.
- Each bus wait cycle adds one cycle.
- Throughput: one request per 3 cycles minimum.

## Structure
- Size encodings (`DMEM_SIZE_B/H/W`) and FSM state encodings go in the shared defines header alongside the `LSU_OPCODE_*` macros.
- One combinational sub-module, `rv32im_dmem_align`, takes addr, size and wdata and produces be8, wdata64 and split. A separate read-merge function can stay inline.

## Test plan
- **LW aligned:** LW at 0x100, ack immediate, rdata 0xDEADBEEF -> bus_addr 0x100, be 1111; rsp_rdata 0xDEADBEEF at T+2.
- **LB:** LB at 0x103, rdata 0x12345678 -> be 1000; rsp_rdata 0x00000012.
- **SW split:** SW at 0x102, wdata 0xAABBCCDD ->
  - access 1: addr 0x100, be 1100, wdata 0xCCDD0000;
  - access 2: addr 0x104, be 0011, wdata 0x0000AABB;
  - rsp_valid only after the second ack, rsp_rdata 0.
- **LH split:** LH at 0x103, words 0x11223344 then 0x55667788 -> be 1000 then 0001; rsp_rdata 0x00008811.
- **Wrap:** LW at 0xFFFFFFFE -> second addr 0x00000000, be 0011.
- **Wait states and reset:**
  - Ack delayed 3 cycles -> bus outputs stable, req_ready 0, a second req_valid is not accepted.
  - `rst_i` asserted during ACC1 -> bus_req 0 next cycle, no rsp_valid, req_ready 1 after reset.
